// File: rtl/delay_meter.sv
// delay_meter: launches a toggle into NUM_CH paths, times the selected one.
// Optional min/max sample outputs: define DELAY_METER_MINMAX_EN.
module delay_meter #(
    parameter int                CNT_W       = 32,
    parameter int                NUM_CH      = 4,
    parameter int                SEL_W       = 2,
    parameter int                TRIALS_LOG2 = 3,
    parameter int                TIMEOUT     = 1000,
    parameter logic [NUM_CH-1:0] INV_MASK    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SEL_W-1:0]             ch_sel,
    input  logic [NUM_CH-1:0]            path_result,
    output logic                         path_in,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [CNT_W+TRIALS_LOG2-1:0] sum,
    output logic [CNT_W-1:0]             avg,
    output logic [CNT_W-1:0]             last
`ifdef DELAY_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0]             min_s,
    output logic [CNT_W-1:0]             max_s
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]     LP_TMAX = CNT_W'(TIMEOUT - 1);
    localparam logic [TRIALS_LOG2:0] LP_NTR  = {1'b1, {TRIALS_LOG2{1'b0}}};

    state_t                       r_state;
    state_t                       w_next;
    logic [NUM_CH-1:0]            r_sync1;
    logic [NUM_CH-1:0]            r_sync2;
    logic [SEL_W-1:0]             r_sel;
    logic                         r_path_in;
    logic                         r_target;
    logic                         r_err;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             r_last;
    logic [TRIALS_LOG2:0]         r_trial;
    logic [TRIALS_LOG2:0]         w_trial_nxt;
    logic [CNT_W+TRIALS_LOG2-1:0] r_sum;
    logic                         w_synced;
    logic                         w_hit;
`ifdef DELAY_METER_MINMAX_EN
    logic [CNT_W-1:0]             r_min;
    logic [CNT_W-1:0]             r_max;
`endif

    assign w_synced    = r_sync2[r_sel];
    assign w_hit       = (w_synced == r_target);
    assign w_trial_nxt = r_trial + 1'b1;

    assign path_in = r_path_in;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;
    assign sum     = r_sum;
    assign avg     = CNT_W'(r_sum >> TRIALS_LOG2);
    assign last    = r_last;
`ifdef DELAY_METER_MINMAX_EN
    assign min_s   = r_min;
    assign max_s   = r_max;
`endif

    // Two-flop synchroniser on every path output, free running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= path_result;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: one trial is LAUNCH, WAIT..., CAPTURE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_hit)                 w_next = S_CAPTURE;
                else if (r_cnt == LP_TMAX) w_next = S_DONE;
            end
            S_CAPTURE: w_next = (w_trial_nxt == LP_NTR) ? S_DONE : S_LAUNCH;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: launch level, cycle counter and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_path_in <= 1'b0;
            r_target  <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_trial   <= '0;
            r_sum     <= '0;
`ifdef DELAY_METER_MINMAX_EN
            r_min     <= '0;
            r_max     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel   <= ch_sel;
                        r_sum   <= '0;
                        r_err   <= 1'b0;
                        r_last  <= '0;
                        r_trial <= '0;
`ifdef DELAY_METER_MINMAX_EN
                        r_min   <= '1;
                        r_max   <= '0;
`endif
                    end
                end
                S_LAUNCH: begin
                    r_path_in <= ~r_path_in;
                    r_target  <= ~r_path_in ^ INV_MASK[r_sel];
                    r_cnt     <= '0;
                end
                S_WAIT: begin
                    // On a hit r_cnt holds still and becomes the sample.
                    if (!w_hit) begin
                        if (r_cnt == LP_TMAX) r_err <= 1'b1;
                        else                  r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_sum   <= r_sum + {{TRIALS_LOG2{1'b0}}, r_cnt};
                    r_last  <= r_cnt;
                    r_trial <= w_trial_nxt;
`ifdef DELAY_METER_MINMAX_EN
                    if (r_cnt < r_min) r_min <= r_cnt;
                    if (r_cnt > r_max) r_max <= r_cnt;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: channel delay models, table vectors, corner sequences and
// randomized runs against a trial-level reference model.
module tb_delay_meter;

    localparam int         CNT_W = 32;
    localparam int         TL    = 3;
    localparam int         NTR   = 1 << TL;
    localparam int         TO    = 100;
    localparam logic [3:0] INV   = 4'b0100;
    localparam longint     ONES  = 64'h0000_0000_FFFF_FFFF;

    logic                  clk         = 1'b0;
    logic                  rst         = 1'b1;
    logic                  start       = 1'b0;
    logic [1:0]            ch_sel      = 2'd0;
    logic [3:0]            path_result = INV;
    logic                  path_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [CNT_W+TL-1:0]   sum;
    logic [CNT_W-1:0]      avg;
    logic [CNT_W-1:0]      last;
`ifdef DELAY_METER_MINMAX_EN
    logic [CNT_W-1:0]      min_s;
    logic [CNT_W-1:0]      max_s;
`endif

    int checks = 0;
    int errors = 0;

    delay_meter #(
        .TIMEOUT (TO),
        .INV_MASK(INV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_sel     (ch_sel),
        .path_result(path_result),
        .path_in    (path_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sum        (sum),
        .avg        (avg),
        .last       (last)
`ifdef DELAY_METER_MINMAX_EN
        ,
        .min_s      (min_s),
        .max_s      (max_s)
`endif
    );

    always #5 clk = ~clk;

    // Path models: each channel follows path_in after its own delay.
    int   dly[4]  = '{default: 0};
    bit   tied[4] = '{default: 0};
    bit   alt[4]  = '{default: 0};
    int   alt_base = 0;
    int   ptog    = 0;
    logic seen    = 1'b0;
    logic lvl[4]  = '{default: 1'b0};
    logic lvo[4]  = '{default: 1'b0};
    int   cd[4]   = '{default: 0};
    bit   pend[4] = '{default: 0};

    always @(negedge clk) begin
        if (path_in !== seen) begin
            seen = path_in;
            for (int c = 0; c < 4; c++) begin
                lvl[c]  = path_in;
                pend[c] = 1'b1;
                if (alt[c]) cd[c] = (((ptog - alt_base) % 2) == 0) ? 4 : 9;
                else        cd[c] = dly[c];
            end
            ptog++;
        end
        for (int c = 0; c < 4; c++) begin
            if (pend[c]) begin
                if (cd[c] == 0) begin
                    lvo[c]  = lvl[c];
                    pend[c] = 1'b0;
                end else begin
                    cd[c]--;
                end
            end
            path_result[c] = tied[c] ? 1'b0 : (lvo[c] ^ INV[c]);
        end
    end

    typedef struct {
        int     ch;
        int     d;
        bit     alt;
        longint esum;
        longint eavg;
        longint elast;
        bit     eerr;
        longint emin;
        longint emax;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Trial-level reference: constant delay d gives sample d+2 per trial.
    function automatic void ref_run(input int d, output longint s,
                                    output longint l, output bit e,
                                    output int lt);
        longint samp;
        samp = longint'(d) + 2;
        s = 0; l = 0; e = 1'b0; lt = 0;
        for (int t = 0; t < NTR; t++) begin
            if (samp > TO - 1) begin
                e = 1'b1;
                lt += 1 + TO;
                break;
            end
            s += samp;
            l = samp;
            lt += int'(samp) + 3;
        end
        lt += 1;
    endfunction

    task automatic do_run(input logic [1:0] ch, output int lat);
        ch_sel = ch;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        chk("busy_on", busy, 1);
        chk("err_clr", err, 0);
        chk("sum_clr", sum, 0);
        chk("last_clr", last, 0);
        while (!done && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_off", busy, 0);
    endtask

    initial begin
        vec_t   tv[7];
        int     lat;
        int     nd;
        int     ch;
        int     d;
        logic   exp_pin;
        longint rs;
        longint rl;
        bit     re;
        int     rlt;

        tv[0] = '{1, 5,  0, 56,  7,  7,  0, 7,    7};
        tv[1] = '{2, 3,  0, 40,  5,  5,  0, 5,    5};
        tv[2] = '{0, 0,  0, 16,  2,  2,  0, 2,    2};
        tv[3] = '{3, 10, 0, 96,  12, 12, 0, 12,   12};
        tv[4] = '{1, 0,  1, 68,  8,  11, 0, 6,    11};
        tv[5] = '{0, 97, 0, 792, 99, 99, 0, 99,   99};
        tv[6] = '{0, 98, 0, 0,   0,  0,  1, ONES, 0};

        rst = 1'b1;
        tick(3);
        chk("rst_path_in", path_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sum", sum, 0);
        chk("rst_avg", avg, 0);
        chk("rst_last", last, 0);
`ifdef DELAY_METER_MINMAX_EN
        chk("rst_min", min_s, 0);
        chk("rst_max", max_s, 0);
`endif
        rst = 1'b0;
        tick(2);
        exp_pin = 1'b0;

        // Timeout with channel 0 stuck low.
        tied[0] = 1'b1;
        tick(20);
        do_run(2'd0, lat);
        exp_pin = ~exp_pin;
        chk("to_latency", lat, 102);
        chk("to_err", err, 1);
        chk("to_sum", sum, 0);
        chk("to_last", last, 0);
        chk("to_path_in", path_in, exp_pin);
`ifdef DELAY_METER_MINMAX_EN
        chk("to_min", min_s, ONES);
        chk("to_max", max_s, 0);
`endif
        tied[0] = 1'b0;

        for (int i = 0; i < 7; i++) begin
            ch = tv[i].ch;
            if (tv[i].alt) begin
                alt_base = ptog;
                alt[ch]  = 1'b1;
            end
            dly[ch] = tv[i].d;
            tick(130);
            do_run(2'(ch), lat);
            if (tv[i].eerr) exp_pin = ~exp_pin;
            chk($sformatf("vec%0d_sum", i), sum, tv[i].esum);
            chk($sformatf("vec%0d_avg", i), avg, tv[i].eavg);
            chk($sformatf("vec%0d_last", i), last, tv[i].elast);
            chk($sformatf("vec%0d_err", i), err, tv[i].eerr);
            chk($sformatf("vec%0d_lat", i), lat,
                tv[i].eerr ? 102 : tv[i].esum + 3 * NTR + 1);
            chk($sformatf("vec%0d_path_in", i), path_in, exp_pin);
`ifdef DELAY_METER_MINMAX_EN
            chk($sformatf("vec%0d_min", i), min_s, tv[i].emin);
            chk($sformatf("vec%0d_max", i), max_s, tv[i].emax);
`endif
            alt[ch] = 1'b0;
        end

        // Start and ch_sel changes during a run must be ignored.
        dly[1] = 5;
        dly[3] = 12;
        tick(130);
        ch_sel = 2'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tick(2);
        ch_sel = 2'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 4;
        while (!done && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_ign_done", done, 1);
        chk("busy_ign_lat", lat, 81);
        chk("busy_ign_sum", sum, 56);
        chk("busy_ign_last", last, 7);
        chk("busy_ign_err", err, 0);
        @(negedge clk);
        chk("busy_ign_pulse", done, 0);
        chk("busy_ign_idle", busy, 0);

        // Asynchronous reset in the middle of trial 4.
        tick(130);
        ch_sel = 2'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tick(34);
        chk("mid_sum", sum, 21);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        chk("mr_sum", sum, 0);
        chk("mr_last", last, 0);
        chk("mr_path_in", path_in, 0);
`ifdef DELAY_METER_MINMAX_EN
        chk("mr_min", min_s, 0);
        chk("mr_max", max_s, 0);
`endif
        tick(2);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mr_no_done", nd, 0);
        chk("mr_idle", busy, 0);
        exp_pin = 1'b0;
        tick(130);
        do_run(2'd1, lat);
        chk("mr_rerun_sum", sum, 56);
        chk("mr_rerun_err", err, 0);
        chk("mr_rerun_path_in", path_in, exp_pin);

        // Randomized runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            ch = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 110));
            dly[ch] = d;
            tick(130);
            do_run(2'(ch), lat);
            ref_run(d, rs, rl, re, rlt);
            if (re) exp_pin = ~exp_pin;
            else    exp_pin = exp_pin ^ NTR[0];
            chk($sformatf("rnd%0d_sum ch%0d d%0d", r, ch, d), sum, rs);
            chk($sformatf("rnd%0d_avg", r), avg, rs >> TL);
            chk($sformatf("rnd%0d_last", r), last, rl);
            chk($sformatf("rnd%0d_err", r), err, re);
            chk($sformatf("rnd%0d_lat", r), lat, rlt);
            chk($sformatf("rnd%0d_path_in", r), path_in, exp_pin);
`ifdef DELAY_METER_MINMAX_EN
            chk($sformatf("rnd%0d_min", r), min_s, re ? ONES : rl);
            chk($sformatf("rnd%0d_max", r), max_s, rl);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_meter.md
Name: delay_meter

Overview:
- Parametrised path-delay measurement engine; successor to the single-path free-running-counter datapath.
- Drives one launch signal into up to NUM_CH delay paths under test and selects one path per run.
- Each trial toggles the launch signal, counts clock cycles until the selected path output reaches the expected level, and accumulates the result over 2^TRIALS_LOG2 trials.
- Per-channel polarity mask handles inverting paths. Sum, average and last sample are reported for host readout.

Parameters:
- CNT_W, 32: width of the per-trial cycle counter and of the avg and last outputs.
- NUM_CH, 4: number of path-result inputs.
- SEL_W, 2: width of ch_sel; NUM_CH <= 2^SEL_W.
- TRIALS_LOG2, 3: log2 of the number of trials per run.
- TIMEOUT, 1000: maximum cycle count per trial; must be <= 2^CNT_W - 1.
- INV_MASK, 0: NUM_CH bits; bit i = 1 means channel i is an inverting path.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- ch_sel  in  SEL_W  channel to measure; latched on an accepted start.
- path_result  in  NUM_CH  outputs of the paths under test; asynchronous to clk.
- path_in  out  1  launch signal driving all paths.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  timeout occurred in the last run; held until the next start.
- sum  out  CNT_W+TRIALS_LOG2  sum of trial samples.
- avg  out  CNT_W  sum >> TRIALS_LOG2.
- last  out  CNT_W  most recent trial sample.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE. path_in, busy, done, err, sum, last, trial counter, cycle counter and synchroniser all go to 0. This applies from any state, mid-trial included; a run in progress is lost with no done pulse.
- Input synchroniser: 2-flop synchroniser on every path_result bit, always running. The selected channel is muxed after the synchroniser using the latched ch_sel.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, DONE.
- IDLE: on start=1, latch ch_sel, clear sum, err, last and the trial counter, then go to LAUNCH. start in any other state is ignored, and ch_sel changes during a run are ignored.
- LAUNCH (1 cycle): toggle path_in. Set target = new path_in XOR INV_MASK[sel]. Clear cnt. Go to WAIT.
- WAIT: each cycle, if the synced selected bit equals target, set sample = cnt and go to CAPTURE. Otherwise:
  - if cnt == TIMEOUT-1: set err=1, go to DONE;
  - else cnt <= cnt+1.
- Fixed offset: a zero-delay path yields sample = 2. A path with d cycles of delay yields d+2. No offset correction is applied in hardware.
- CAPTURE (1 cycle): sum <= sum + sample; last <= sample; trial counter += 1.
  - If the trial counter reaches 2^TRIALS_LOG2, go to DONE; else go to LAUNCH.
  - path_in alternates polarity every trial, so rising and falling launches are both measured.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
  - sum, avg, last and err hold until the next accepted start.
  - On timeout, sum holds the completed trials only.
- cnt never wraps, because TIMEOUT bounds it. sum width prevents overflow.
- avg is combinational from sum.
- path_in is not reset between runs; each run continues from its current level.

Optional Feature:
- Macro: DELAY_METER_MINMAX_EN.
- Defined: adds outputs min_s and max_s, each CNT_W wide.
  - Both reset to 0.
  - On an accepted start: min_s <= all ones, max_s <= 0.
  - At each CAPTURE: both are updated against sample.
  - Both hold after DONE.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Default params; channel 1 modelled as a 5-cycle delay buffer; start with ch_sel=1 -> 8 trials, each sample=7, last=7, sum=56, avg=7, err=0, one done pulse, path_in ends at 0.
- INV_MASK=4'b0100; channel 2 is a 3-cycle inverter; ch_sel=2 -> avg=5, sum=40, err=0.
- TIMEOUT=100; channel 0 tied low; start -> err=1, done pulses 100 cycles after the WAIT entry, sum=0, busy low afterwards.
- While busy: pulse start again and change ch_sel from 1 to 3 -> no restart; results equal the undisturbed channel-1 run (sum=56).
- Assert rst mid-WAIT on trial 4 -> all outputs 0 immediately, FSM IDLE, no done pulse; a new start completes normally with sum=56.
- DELAY_METER_MINMAX_EN defined; channel delay alternates 4 and 9 cycles -> min_s=6, max_s=11, sum=68, avg=8.
